// File: rtl/unidade_controle_pkg.sv
// Shared encodings for the main decoder: instruction classes, funct codes,
// datapath select encodings and the packed control vector with its NOP value.
package unidade_controle_pkg;

    localparam logic [1:0] OPC_R    = 2'b00;
    localparam logic [1:0] OPC_IMM  = 2'b01;
    localparam logic [1:0] OPC_MEM  = 2'b10;
    localparam logic [1:0] OPC_CTRL = 2'b11;

    localparam logic [2:0] FUNCT_LW   = 3'b000;
    localparam logic [2:0] FUNCT_SW   = 3'b001;
    localparam logic [2:0] FUNCT_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT_J    = 3'b001;
    localparam logic [2:0] FUNCT_JR   = 3'b010;
    localparam logic [2:0] FUNCT_JAL  = 3'b011;
    localparam logic [2:0] FUNCT_HALT = 3'b111;
    localparam logic [2:0] FUNCT_LI   = 3'b111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_IMM = 2'b11;

    localparam logic [1:0] SRC2_REG = 2'b00;
    localparam logic [1:0] SRC2_IMM = 2'b01;
    localparam logic [1:0] SRC2_ONE = 2'b10;

    localparam logic [1:0] JV_REL = 2'b00;
    localparam logic [1:0] JV_ABS = 2'b01;
    localparam logic [1:0] JV_REG = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       reg_org1;
        logic       reg_org2;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src1;
        logic [1:0] alu_src2;
        logic [1:0] alu_op;
        logic [1:0] jump_value;
        logic       cond;
        logic       jump;
        logic       men_write;
        logic       men_read;
        logic       men_to_reg;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        pc_write:   1'b1,
        reg_org1:   1'b0,
        reg_org2:   1'b0,
        reg_dst:    1'b0,
        reg_write:  1'b0,
        alu_src1:   1'b0,
        alu_src2:   2'b00,
        alu_op:     2'b00,
        jump_value: 2'b00,
        cond:       1'b0,
        jump:       1'b0,
        men_write:  1'b0,
        men_read:   1'b0,
        men_to_reg: 1'b0
    };

endpackage

// File: rtl/unidade_controle_decode.sv
// Purely combinational Opcode/Funct to control-vector decoder.
// Anything not listed below falls through to the NOP vector.
module unidade_controle_decode
    import unidade_controle_pkg::*;
(
    input  logic [1:0] opcode_i,
    input  logic [2:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = NOP_CTRL;
        unique case (opcode_i)
            OPC_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.alu_op    = ALUOP_R;
            end
            OPC_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src2  = SRC2_IMM;
                ctrl_o.alu_op    = ALUOP_IMM;
                // Load immediate adds the immediate to r0.
                ctrl_o.reg_org1  = (funct_i == FUNCT_LI);
            end
            OPC_MEM: begin
                if (funct_i == FUNCT_LW) begin
                    ctrl_o.men_read   = 1'b1;
                    ctrl_o.men_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.alu_src2   = SRC2_IMM;
                    ctrl_o.alu_op     = ALUOP_ADD;
                end else if (funct_i == FUNCT_SW) begin
                    ctrl_o.men_write = 1'b1;
                    ctrl_o.reg_org2  = 1'b1;
                    ctrl_o.alu_src2  = SRC2_IMM;
                    ctrl_o.alu_op    = ALUOP_ADD;
                end
            end
            OPC_CTRL: begin
                case (funct_i)
                    FUNCT_BEQ: begin
                        ctrl_o.jump       = 1'b1;
                        ctrl_o.cond       = 1'b1;
                        ctrl_o.alu_op     = ALUOP_SUB;
                        ctrl_o.jump_value = JV_REL;
                    end
                    FUNCT_J: begin
                        ctrl_o.jump       = 1'b1;
                        ctrl_o.jump_value = JV_ABS;
                    end
                    FUNCT_JR: begin
                        ctrl_o.jump       = 1'b1;
                        ctrl_o.jump_value = JV_REG;
                    end
                    FUNCT_JAL: begin
                        // Link: ALU computes PC + 1 into rd.
                        ctrl_o.jump       = 1'b1;
                        ctrl_o.jump_value = JV_ABS;
                        ctrl_o.reg_write  = 1'b1;
                        ctrl_o.reg_dst    = 1'b1;
                        ctrl_o.alu_src1   = 1'b1;
                        ctrl_o.alu_src2   = SRC2_ONE;
                        ctrl_o.alu_op     = ALUOP_ADD;
                    end
                    FUNCT_HALT: ctrl_o = '0;
                    default:    ctrl_o = NOP_CTRL;
                endcase
            end
            default: ctrl_o = NOP_CTRL;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Main decoder of the 8-bit processor: decodes Opcode/Funct and registers the
// control strobes with one clock of latency; reset clears every output.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Opcode,
    input  logic [2:0] Funct,
    output logic       PCWrite,
    output logic       RegOrg1,
    output logic       RegOrg2,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic [1:0] ALUOp,
    output logic [1:0] JumpValue,
    output logic       Cond,
    output logic       Jump,
    output logic       MenWrite,
    output logic       MenRead,
    output logic       MenToReg
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    unidade_controle_decode u_decode (
        .opcode_i (Opcode),
        .funct_i  (Funct),
        .ctrl_o   (ctrl_d)
    );

    // Reset clears PCWrite too, so the PC holds while reset is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign PCWrite   = ctrl_q.pc_write;
    assign RegOrg1   = ctrl_q.reg_org1;
    assign RegOrg2   = ctrl_q.reg_org2;
    assign RegDst    = ctrl_q.reg_dst;
    assign RegWrite  = ctrl_q.reg_write;
    assign ALUSrc1   = ctrl_q.alu_src1;
    assign ALUSrc2   = ctrl_q.alu_src2;
    assign ALUOp     = ctrl_q.alu_op;
    assign JumpValue = ctrl_q.jump_value;
    assign Cond      = ctrl_q.cond;
    assign Jump      = ctrl_q.jump;
    assign MenWrite  = ctrl_q.men_write;
    assign MenRead   = ctrl_q.men_read;
    assign MenToReg  = ctrl_q.men_to_reg;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: reset, each instruction class, latency,
// and a full 32-entry Opcode/Funct sweep with invariant checks.
module tb_unidade_controle;

    // Vector layout: {PCWrite, RegOrg1, RegOrg2, RegDst, RegWrite, ALUSrc1,
    //   ALUSrc2[1:0], ALUOp[1:0], JumpValue[1:0], Cond, Jump, MenWrite, MenRead, MenToReg}
    localparam logic [16:0] V_NOP  = 17'b1_0_0_0_0_0_00_00_00_0_0_0_0_0;
    localparam logic [16:0] V_R    = 17'b1_0_0_1_1_0_00_10_00_0_0_0_0_0;
    localparam logic [16:0] V_IMM  = 17'b1_0_0_0_1_0_01_11_00_0_0_0_0_0;
    localparam logic [16:0] V_LI   = 17'b1_1_0_0_1_0_01_11_00_0_0_0_0_0;
    localparam logic [16:0] V_LW   = 17'b1_0_0_0_1_0_01_00_00_0_0_0_1_1;
    localparam logic [16:0] V_SW   = 17'b1_0_1_0_0_0_01_00_00_0_0_1_0_0;
    localparam logic [16:0] V_BEQ  = 17'b1_0_0_0_0_0_00_01_00_1_1_0_0_0;
    localparam logic [16:0] V_J    = 17'b1_0_0_0_0_0_00_00_01_0_1_0_0_0;
    localparam logic [16:0] V_JR   = 17'b1_0_0_0_0_0_00_00_10_0_1_0_0_0;
    localparam logic [16:0] V_JAL  = 17'b1_0_0_1_1_1_10_00_01_0_1_0_0_0;
    localparam logic [16:0] V_HALT = 17'b0_0_0_0_0_0_00_00_00_0_0_0_0_0;

    logic       clk;
    logic       reset;
    logic [1:0] Opcode;
    logic [2:0] Funct;
    logic       PCWrite, RegOrg1, RegOrg2, RegDst, RegWrite, ALUSrc1;
    logic [1:0] ALUSrc2, ALUOp, JumpValue;
    logic       Cond, Jump, MenWrite, MenRead, MenToReg;

    int n_tests;
    int n_fail;

    unidade_controle dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .PCWrite   (PCWrite),
        .RegOrg1   (RegOrg1),
        .RegOrg2   (RegOrg2),
        .RegDst    (RegDst),
        .RegWrite  (RegWrite),
        .ALUSrc1   (ALUSrc1),
        .ALUSrc2   (ALUSrc2),
        .ALUOp     (ALUOp),
        .JumpValue (JumpValue),
        .Cond      (Cond),
        .Jump      (Jump),
        .MenWrite  (MenWrite),
        .MenRead   (MenRead),
        .MenToReg  (MenToReg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] observed();
        return {PCWrite, RegOrg1, RegOrg2, RegDst, RegWrite, ALUSrc1,
                ALUSrc2, ALUOp, JumpValue, Cond, Jump, MenWrite, MenRead, MenToReg};
    endfunction

    // Hand-written decode table
    function automatic logic [16:0] expected(input logic [1:0] op, input logic [2:0] fn);
        logic [16:0] v;
        v = V_NOP;
        if (op == 2'b00) v = V_R;
        else if (op == 2'b01) v = (fn == 3'b111) ? V_LI : V_IMM;
        else if (op == 2'b10) begin
            if (fn == 3'b000) v = V_LW;
            else if (fn == 3'b001) v = V_SW;
        end else begin
            case (fn)
                3'b000:  v = V_BEQ;
                3'b001:  v = V_J;
                3'b010:  v = V_JR;
                3'b011:  v = V_JAL;
                3'b111:  v = V_HALT;
                default: v = V_NOP;
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic check_invariants(input string tag);
        check({tag, "_mem_excl"}, {16'b0, MenWrite & MenRead}, 17'd0);
        check({tag, "_m2r_rw"},   {16'b0, MenToReg & ~RegWrite}, 17'd0);
        check({tag, "_cond_j"},   {16'b0, Cond & ~Jump}, 17'd0);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic [1:0] op, input logic [2:0] fn);
        @(negedge clk);
        Opcode = op;
        Funct  = fn;
    endtask

    task automatic step(input string tag, input logic [1:0] op, input logic [2:0] fn,
                        input logic [16:0] exp);
        drive(op, fn);
        @(posedge clk);
        #1;
        check(tag, observed(), exp);
    endtask

    initial begin
        logic [4:0] v;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        Opcode  = 2'b00;
        Funct   = 3'b000;

        #1;
        check("reset_init", observed(), 17'd0);
        @(posedge clk);
        #1;
        check("reset_held_edge", observed(), 17'd0);

        // Release with R-type pending
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_rtype", observed(), V_R);

        step("lw",  2'b10, 3'b000, V_LW);
        step("sw",  2'b10, 3'b001, V_SW);
        step("beq", 2'b11, 3'b000, V_BEQ);
        step("jr",  2'b11, 3'b010, V_JR);
        step("jal", 2'b11, 3'b011, V_JAL);
        step("j",   2'b11, 3'b001, V_J);
        step("li",  2'b01, 3'b111, V_LI);
        step("halt", 2'b11, 3'b111, V_HALT);
        step("undef_mem", 2'b10, 3'b101, V_NOP);

        // Latency: input change between edges must not reach the outputs
        step("lat_imm", 2'b01, 3'b000, V_IMM);
        #2;
        Opcode = 2'b10;
        #1;
        check("lat_hold", observed(), V_IMM);
        @(posedge clk);
        #1;
        check("lat_lw", observed(), V_LW);
        #2;
        Funct = 3'b101;
        #1;
        check("lat_hold2", observed(), V_LW);
        @(posedge clk);
        #1;
        check("lat_nop", observed(), V_NOP);

        // Asynchronous reset mid-cycle
        step("pre_reset_jal", 2'b11, 3'b011, V_JAL);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", observed(), 17'd0);
        drive(2'b00, 3'b000);
        @(posedge clk);
        #1;
        check("reset_hold", observed(), 17'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel_rtype", observed(), V_R);

        // Exhaustive sweep
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            step($sformatf("sweep_%0d%0d%0d%0d%0d", v[4], v[3], v[2], v[1], v[0]),
                 v[4:3], v[2:0], expected(v[4:3], v[2:0]));
            check_invariants($sformatf("sweep_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Main decoder of the 8-bit processor.
- Turns the 2-bit Opcode and 3-bit Funct fields of the current instruction into datapath control strobes: PC, register file, ALU, branch/jump and data memory.
- Outputs are registered: one clock of latency, cleared by an asynchronous reset.
- Sits between the instruction register and the datapath.

Parameters:
- None. All encodings are fixed constants in the shared package.

Ports:
- clk  in  1  system clock; rising edge active
- reset  in  1  asynchronous, active-high; clears all outputs
- Opcode  in  2  instruction class: 00 R-type, 01 immediate ALU, 10 memory, 11 control flow
- Funct  in  3  operation within the class
- PCWrite  out  1  PC update enable; 0 = hold PC (halt/reset)
- RegOrg1  out  1  read port 1 source: 0 = rs field, 1 = r0 (constant zero)
- RegOrg2  out  1  read port 2 source: 0 = rt field, 1 = rd field
- RegDst  out  1  write register: 0 = rt field, 1 = rd field
- RegWrite  out  1  register file write enable
- ALUSrc1  out  1  ALU A operand: 0 = read port 1, 1 = PC
- ALUSrc2  out  2  ALU B operand: 00 read port 2, 01 sign-extended immediate, 10 constant 1, 11 reserved
- ALUOp  out  2  00 add, 01 subtract/compare, 10 R-type (ALU decodes Funct), 11 immediate op (ALU decodes Funct)
- JumpValue  out  2  target: 00 PC+immediate, 01 absolute immediate, 10 read port 1, 11 reserved
- Cond  out  1  1 = jump qualified by ALU zero flag
- Jump  out  1  1 = select jump target path
- MenWrite  out  1  data memory write enable
- MenRead  out  1  data memory read enable
- MenToReg  out  1  writeback source: 0 = ALU, 1 = memory

Behaviour:
- Reset asserted: every output is 0 immediately, including PCWrite. Outputs stay 0 while reset is high.
- First decode is captured on the first rising clk edge after reset deasserts.
- Latency: outputs reflect the Opcode/Funct sampled at the previous rising edge.
- Input changes between edges have no effect on the outputs.
- Default (NOP) vector: PCWrite=1, all other outputs 0.
- Each instruction below lists only the fields that differ from NOP. Unlisted Opcode/Funct combinations yield NOP.
- Opcode 00, any Funct (R-type):
  - RegWrite=1, RegDst=1, ALUOp=10.
- Opcode 01, any Funct (immediate ALU):
  - RegWrite=1, RegDst=0, ALUSrc2=01, ALUOp=11.
  - Funct 111 (load immediate) additionally sets RegOrg1=1.
- Opcode 10, Funct 000 (lw):
  - MenRead=1, MenToReg=1, RegWrite=1, ALUSrc2=01, ALUOp=00.
- Opcode 10, Funct 001 (sw):
  - MenWrite=1, RegOrg2=1, ALUSrc2=01, ALUOp=00.
- Opcode 11, Funct 000 (beq):
  - Jump=1, Cond=1, ALUOp=01, JumpValue=00.
- Opcode 11, Funct 001 (j):
  - Jump=1, JumpValue=01.
- Opcode 11, Funct 010 (jr):
  - Jump=1, JumpValue=10.
- Opcode 11, Funct 011 (jal):
  - Jump=1, JumpValue=01, RegWrite=1, RegDst=1, ALUSrc1=1, ALUSrc2=10, ALUOp=00. Writes PC+1 to rd.
- Opcode 11, Funct 111 (halt):
  - PCWrite=0, all other outputs 0.
- Invariants:
  - MenWrite and MenRead are never both 1.
  - MenToReg=1 implies RegWrite=1.
  - Cond=1 implies Jump=1.
- Reset asserted mid-operation: outputs clear asynchronously; no partial state is retained.
- The block has no state besides the output register.

Decomposition:
- Package unidade_controle_pkg holds:
  - Opcode class constants.
  - Funct constants for lw, sw, beq, j, jr, jal, halt and li.
  - ALUOp, ALUSrc2 and JumpValue encodings.
  - The NOP control vector.
- One natural sub-module: unidade_controle_decode, a purely combinational Opcode/Funct-to-control-vector decoder.
- The top level instantiates the decoder and adds the async-reset output register.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 before the next clk edge. Release reset with Opcode=00 Funct=000 -> after one edge PCWrite=1, RegWrite=1, RegDst=1, ALUOp=10, others 0.
- Memory: Opcode=10 Funct=000 -> next cycle MenRead=1, MenToReg=1, RegWrite=1, ALUSrc2=01, MenWrite=0. Opcode=10 Funct=001 -> MenWrite=1, RegOrg2=1, RegWrite=0, MenRead=0.
- Control flow: Opcode=11 Funct=000 -> Jump=1, Cond=1, ALUOp=01, JumpValue=00. Funct=010 -> Jump=1, Cond=0, JumpValue=10. Funct=011 -> ALUSrc1=1, ALUSrc2=10, RegWrite=1, JumpValue=01.
- Halt and undefined: Opcode=11 Funct=111 -> PCWrite=0 and all outputs 0. Opcode=10 Funct=101 -> NOP vector (PCWrite=1 only).
- Latency: change Opcode 01->10 between clock edges -> outputs unchanged until the next rising edge, then show the lw/NOP vector for the new value.
- Exhaustive sweep: all 32 Opcode/Funct combinations, one per clock -> each output vector matches the decode table, delayed one cycle. All invariants hold on every cycle.
